// File: rtl/data_cache_pkg.sv
// Shared widths, FSM encodings and byte-merge helper for the data cache.
// No logic of its own; imported by the interface, line array and top.
package data_cache_pkg;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int INDEX_W = 6;
   localparam int MASK_W  = 4;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_MEM  = 3'd1;
   localparam logic [2:0] WR_MEM  = 3'd2;
   localparam logic [2:0] RD_RESP = 3'd3;
   localparam logic [2:0] WR_RESP = 3'd4;

   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] new_word,
      input logic [MASK_W-1:0] mask
   );
      logic [DATA_W-1:0] res;
      res = old_word;
      for (int i = 0; i < MASK_W; i++) begin
         if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/data_cache_if.sv
// Load, store and memory-port signals of the data cache in one bundle.
// slave is the cache side, master is the core/memory environment side.
interface data_cache_if #(
   parameter int ADDR_WIDTH = data_cache_pkg::ADDR_W,
   parameter int DATA_WIDTH = data_cache_pkg::DATA_W
);
   logic                  lsm_dcache_read;
   logic [ADDR_WIDTH-1:0] lsm_dcache_read_addr;
   logic                  dcache_lsm_read_done;
   logic [DATA_WIDTH-1:0] dcache_lsm_read_data;

   logic                  rob_dcache_write;
   logic [3:0]            rob_dcache_mask;
   logic [ADDR_WIDTH-1:0] rob_dcache_addr;
   logic [DATA_WIDTH-1:0] rob_dcache_data;
   logic                  dcache_rob_valid;

   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [3:0]            mem_mask;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  lsm_dcache_read, lsm_dcache_read_addr,
      output dcache_lsm_read_done, dcache_lsm_read_data,
      input  rob_dcache_write, rob_dcache_mask, rob_dcache_addr, rob_dcache_data,
      output dcache_rob_valid,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
      input  mem_ack, mem_rdata
   );

   modport master (
      output lsm_dcache_read, lsm_dcache_read_addr,
      input  dcache_lsm_read_done, dcache_lsm_read_data,
      output rob_dcache_write, rob_dcache_mask, rob_dcache_addr, rob_dcache_data,
      input  dcache_rob_valid,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational hit lookup,
// line fill and masked byte write, both taking effect on the next clock edge.
module dcache_line_array
   import data_cache_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int INDEX_BITS = INDEX_W,
   parameter int TAG_BITS   = ADDR_W - INDEX_W - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] index,
   input  logic [TAG_BITS-1:0]   tag,
   output logic                  hit,
   output logic [DATA_WIDTH-1:0] hit_data,
   input  logic                  fill_en,
   input  logic [DATA_WIDTH-1:0] fill_data,
   input  logic                  wr_en,
   input  logic [MASK_W-1:0]     wr_mask,
   input  logic [DATA_WIDTH-1:0] wr_data
);
   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]      valid;
   logic [TAG_BITS-1:0]   tags [LINES];
   logic [DATA_WIDTH-1:0] data [LINES];

   assign hit      = valid[index] && (tags[index] == tag);
   assign hit_data = data[index];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          valid        <= '0;
      else if (fill_en) valid[index] <= 1'b1;
   end

   // Tag and data carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tags[index] <= tag;
         data[index] <= fill_data;
      end else if (wr_en) begin
         data[index] <= merge_bytes(data[index], wr_data, wr_mask);
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache; load hit 1 cycle,
// miss/store = memory latency + 2. Level-held requests simply wait outside IDLE.
module data_cache
   import data_cache_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int DATA_WIDTH = DATA_W,
   parameter int INDEX_BITS = INDEX_W
) (
   input logic         clk,
   input logic         rst,
   data_cache_if.slave bus
);
   localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] lookup_addr;
   logic                  hit;
   logic [DATA_WIDTH-1:0] hit_data;
   logic                  fill_en;
   logic                  wr_en;
   logic                  unused_bits;

   // mem_addr doubles as the latched request address once we leave IDLE.
   assign lookup_addr = (state == IDLE) ? bus.lsm_dcache_read_addr : bus.mem_addr;
   assign fill_en     = (state == RD_MEM) && bus.mem_ack;
   assign wr_en       = (state == WR_MEM) && bus.mem_ack && hit;
   assign unused_bits = ^{bus.lsm_dcache_read_addr[1:0], bus.rob_dcache_addr[1:0],
                          bus.mem_addr[1:0]};

   assign bus.dcache_lsm_read_done = (state == RD_RESP);
   assign bus.dcache_rob_valid     = (state == WR_RESP);

   dcache_line_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_lines (
      .clk       (clk),
      .rst       (rst),
      .index     (lookup_addr[INDEX_BITS+1:2]),
      .tag       (lookup_addr[ADDR_WIDTH-1:INDEX_BITS+2]),
      .hit       (hit),
      .hit_data  (hit_data),
      .fill_en   (fill_en),
      .fill_data (bus.mem_rdata),
      .wr_en     (wr_en),
      .wr_mask   (bus.mem_mask),
      .wr_data   (bus.mem_wdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                    <= IDLE;
         bus.mem_req              <= 1'b0;
         bus.mem_we               <= 1'b0;
         bus.mem_addr             <= '0;
         bus.mem_wdata            <= '0;
         bus.mem_mask             <= '0;
         bus.dcache_lsm_read_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Stores commit first so a same-cycle load observes their data.
               if (bus.rob_dcache_write) begin
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= {bus.rob_dcache_addr[ADDR_WIDTH-1:2], 2'b00};
                  bus.mem_wdata <= bus.rob_dcache_data;
                  bus.mem_mask  <= bus.rob_dcache_mask;
                  state         <= WR_MEM;
               end else if (bus.lsm_dcache_read) begin
                  if (hit) begin
                     bus.dcache_lsm_read_data <= hit_data;
                     state                    <= RD_RESP;
                  end else begin
                     bus.mem_req  <= 1'b1;
                     bus.mem_we   <= 1'b0;
                     bus.mem_addr <= {bus.lsm_dcache_read_addr[ADDR_WIDTH-1:2], 2'b00};
                     bus.mem_mask <= 4'b0000;
                     state        <= RD_MEM;
                  end
               end
            end
            WR_MEM: begin
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  state       <= WR_RESP;
               end
            end
            RD_MEM: begin
               if (bus.mem_ack) begin
                  bus.dcache_lsm_read_data <= bus.mem_rdata;
                  bus.mem_req              <= 1'b0;
                  state                    <= RD_RESP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboarded bench for data_cache: a latency-programmable memory responder,
// a completion monitor popping expected results, and one task per scenario.
module tb_data_cache;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_cache_if bus();

   data_cache u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic        is_load;
      logic [31:0] data;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   logic [31:0] mem_model [logic [31:0]];
   int          mem_lat   = 3;
   int          n_rd_req  = 0;
   int          n_wr_req  = 0;
   logic [31:0] last_addr = '0;
   logic        last_we   = 1'b0;
   logic [3:0]  last_mask = '0;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory responder: acks mem_lat cycles after first seeing mem_req.
   initial begin
      bit pending;
      int cnt;
      logic [31:0] w;
      pending = 0;
      cnt = 0;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            pending = 0;
         end else if (!bus.mem_req || rst) begin
            pending = 0;
         end else if (!pending) begin
            pending = 1;
            cnt = mem_lat;
            if (bus.mem_we) n_wr_req++; else n_rd_req++;
            last_addr = bus.mem_addr;
            last_we   = bus.mem_we;
            last_mask = bus.mem_mask;
         end else begin
            cnt--;
            if (cnt <= 0) begin
               bus.mem_ack = 1'b1;
               if (bus.mem_we) begin
                  w = mem_read(bus.mem_addr);
                  for (int i = 0; i < 4; i++)
                     if (bus.mem_mask[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
                  mem_model[bus.mem_addr] = w;
               end else begin
                  bus.mem_rdata = mem_read(bus.mem_addr);
               end
            end
         end
      end
   end

   // Completion monitor: every done/valid pulse must match the next expectation.
   initial begin
      forever begin
         exp_t e;
         @(posedge clk);
         #1;
         if (bus.dcache_lsm_read_done || bus.dcache_rob_valid) begin
            checks++;
            if (bus.dcache_lsm_read_done && bus.dcache_rob_valid) begin
               errors++;
               $display("FAIL sb_both_pulses: read_done=1 rob_valid=1, required one at a time");
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: read_done=%0b rob_valid=%0b with nothing expected",
                        bus.dcache_lsm_read_done, bus.dcache_rob_valid);
            end else begin
               e = exp_q.pop_front();
               if (bus.dcache_lsm_read_done !== e.is_load) begin
                  errors++;
                  $display("FAIL sb_kind: got load=%0b, required load=%0b",
                           bus.dcache_lsm_read_done, e.is_load);
               end else if (e.is_load && bus.dcache_lsm_read_data !== e.data) begin
                  errors++;
                  $display("FAIL sb_load_data: got %h, required %h",
                           bus.dcache_lsm_read_data, e.data);
               end
            end
         end
      end
   end

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [31:0] exp, output int cycles);
      exp_q.push_back('{is_load: 1'b1, data: exp});
      bus.lsm_dcache_read = 1'b1;
      bus.lsm_dcache_read_addr = addr;
      cycles = 0;
      while (1) begin
         @(posedge clk);
         #1;
         cycles++;
         if (bus.dcache_lsm_read_done) break;
         if (cycles > 200) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: addr %h no read_done after %0d cycles", addr, cycles);
            break;
         end
      end
      bus.lsm_dcache_read = 1'b0;
      idle_cycle();
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
      int cycles;
      exp_q.push_back('{is_load: 1'b0, data: 32'h0});
      bus.rob_dcache_write = 1'b1;
      bus.rob_dcache_addr = addr;
      bus.rob_dcache_data = data;
      bus.rob_dcache_mask = mask;
      cycles = 0;
      while (1) begin
         @(posedge clk);
         #1;
         cycles++;
         if (bus.dcache_rob_valid) break;
         if (cycles > 200) begin
            checks++;
            errors++;
            $display("FAIL store_timeout: addr %h no rob_valid after %0d cycles", addr, cycles);
            break;
         end
      end
      bus.rob_dcache_write = 1'b0;
      idle_cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.lsm_dcache_read = 1'b0;
      bus.lsm_dcache_read_addr = '0;
      bus.rob_dcache_write = 1'b0;
      bus.rob_dcache_addr = '0;
      bus.rob_dcache_data = '0;
      bus.rob_dcache_mask = '0;
      repeat (3) idle_cycle();
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.dcache_lsm_read_done, bus.dcache_rob_valid} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctrl: req/we/done/valid=%b, required 0000",
                  {bus.mem_req, bus.mem_we, bus.dcache_lsm_read_done, bus.dcache_rob_valid});
      end
      checks++;
      if ({bus.mem_addr, bus.mem_wdata, bus.mem_mask, bus.dcache_lsm_read_data} !== '0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h mask=%b rdata=%h, required all 0",
                  bus.mem_addr, bus.mem_wdata, bus.mem_mask, bus.dcache_lsm_read_data);
      end
      rst = 1'b0;
      idle_cycle();
   endtask

   task automatic test_cold_load();
      int rd0, cyc;
      rd0 = n_rd_req;
      do_load(32'h100, 32'hDEADBEEF, cyc);
      checks++;
      if (n_rd_req !== rd0 + 1 || last_we !== 1'b0 || last_addr !== 32'h100 || last_mask !== 4'b0) begin
         errors++;
         $display("FAIL cold_load_mem: reads=%0d we=%b addr=%h mask=%b, required reads=%0d we=0 addr=100 mask=0000",
                  n_rd_req - rd0, last_we, last_addr, last_mask, 1);
      end
      rd0 = n_rd_req;
      do_load(32'h100, 32'hDEADBEEF, cyc);
      checks++;
      if (cyc !== 1 || n_rd_req !== rd0) begin
         errors++;
         $display("FAIL hit_latency: cycles=%0d new_reads=%0d, required 1 and 0", cyc, n_rd_req - rd0);
      end
   endtask

   task automatic test_store_hit();
      int rd0, wr0, cyc;
      wr0 = n_wr_req;
      do_store(32'h100, 32'h11223344, 4'b0011);
      checks++;
      if (n_wr_req !== wr0 + 1 || last_we !== 1'b1 || last_addr !== 32'h100 || last_mask !== 4'b0011) begin
         errors++;
         $display("FAIL store_hit_mem: writes=%0d we=%b addr=%h mask=%b, required 1 1 100 0011",
                  n_wr_req - wr0, last_we, last_addr, last_mask);
      end
      rd0 = n_rd_req;
      do_load(32'h100, 32'hDEAD3344, cyc);
      checks++;
      if (cyc !== 1 || n_rd_req !== rd0) begin
         errors++;
         $display("FAIL store_merge_hit: cycles=%0d new_reads=%0d, required 1 and 0", cyc, n_rd_req - rd0);
      end
   endtask

   task automatic test_store_miss();
      int rd0, wr0, cyc;
      wr0 = n_wr_req;
      do_store(32'h202, 32'hA0B0C0D0, 4'b1100);
      checks++;
      if (n_wr_req !== wr0 + 1 || last_addr !== 32'h200 || last_mask !== 4'b1100) begin
         errors++;
         $display("FAIL store_miss_mem: writes=%0d addr=%h mask=%b, required 1 200 1100",
                  n_wr_req - wr0, last_addr, last_mask);
      end
      rd0 = n_rd_req;
      do_load(32'h200, 32'hA0B00200, cyc);
      checks++;
      if (n_rd_req !== rd0 + 1) begin
         errors++;
         $display("FAIL no_write_allocate: new_reads=%0d, required 1", n_rd_req - rd0);
      end
   endtask

   task automatic test_same_cycle();
      int rd0, wr0, cyc, t_valid, t_done;
      rd0 = n_rd_req;
      wr0 = n_wr_req;
      exp_q.push_back('{is_load: 1'b0, data: 32'h0});
      exp_q.push_back('{is_load: 1'b1, data: 32'hCAFEF00D});
      bus.rob_dcache_write = 1'b1;
      bus.rob_dcache_addr = 32'h300;
      bus.rob_dcache_data = 32'hCAFEF00D;
      bus.rob_dcache_mask = 4'b1111;
      bus.lsm_dcache_read = 1'b1;
      bus.lsm_dcache_read_addr = 32'h300;
      cyc = 0;
      t_valid = 0;
      t_done = 0;
      while (t_done == 0 && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.dcache_rob_valid) begin
            t_valid = cyc;
            bus.rob_dcache_write = 1'b0;
         end
         if (bus.dcache_lsm_read_done) begin
            t_done = cyc;
            bus.lsm_dcache_read = 1'b0;
         end
      end
      bus.rob_dcache_write = 1'b0;
      bus.lsm_dcache_read = 1'b0;
      idle_cycle();
      checks++;
      if (t_valid == 0 || t_done <= t_valid) begin
         errors++;
         $display("FAIL same_cycle_order: rob_valid at %0d read_done at %0d, required valid first", t_valid, t_done);
      end
      checks++;
      if (n_wr_req !== wr0 + 1 || n_rd_req !== rd0 + 1) begin
         errors++;
         $display("FAIL same_cycle_mem: writes=%0d reads=%0d, required 1 and 1", n_wr_req - wr0, n_rd_req - rd0);
      end
   endtask

   task automatic test_alias();
      int rd0, cyc;
      rd0 = n_rd_req;
      do_load(32'h100, 32'hDEAD3344, cyc);
      do_load(32'h200, 32'hA0B00200, cyc);
      do_load(32'h100, 32'hDEAD3344, cyc);
      checks++;
      if (n_rd_req !== rd0 + 3 || cyc <= 1) begin
         errors++;
         $display("FAIL alias_refill: new_reads=%0d last_cycles=%0d, required 3 and >1", n_rd_req - rd0, cyc);
      end
   endtask

   task automatic test_reset_mid();
      int rd0, cyc;
      do_load(32'h100, 32'hDEAD3344, cyc);
      checks++;
      if (cyc !== 1) begin
         errors++;
         $display("FAIL pre_reset_hit: cycles=%0d, required 1", cyc);
      end
      mem_lat = 8;
      bus.lsm_dcache_read = 1'b1;
      bus.lsm_dcache_read_addr = 32'h200;
      cyc = 0;
      while (!bus.mem_req && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (!bus.mem_req) begin
         errors++;
         $display("FAIL reset_mid_req: mem_req=%b, required 1 before reset", bus.mem_req);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_async_req: mem_req=%b, required 0 without a clock edge", bus.mem_req);
      end
      bus.lsm_dcache_read = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle_cycle();
         checks++;
         if (bus.dcache_lsm_read_done !== 1'b0 || bus.dcache_rob_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_done_low: done=%b valid=%b, required 0 0",
                     bus.dcache_lsm_read_done, bus.dcache_rob_valid);
         end
      end
      rst = 1'b0;
      mem_lat = 3;
      idle_cycle();
      rd0 = n_rd_req;
      do_load(32'h100, 32'hDEAD3344, cyc);
      checks++;
      if (n_rd_req !== rd0 + 1) begin
         errors++;
         $display("FAIL reset_invalidate: new_reads=%0d, required 1", n_rd_req - rd0);
      end
   endtask

   task automatic test_zero_mask();
      int rd0, wr0, cyc;
      wr0 = n_wr_req;
      do_store(32'h100, 32'hFFFFFFFF, 4'b0000);
      checks++;
      if (n_wr_req !== wr0 + 1 || last_mask !== 4'b0000) begin
         errors++;
         $display("FAIL zero_mask_mem: writes=%0d mask=%b, required 1 0000", n_wr_req - wr0, last_mask);
      end
      rd0 = n_rd_req;
      do_load(32'h100, 32'hDEAD3344, cyc);
      checks++;
      if (cyc !== 1 || n_rd_req !== rd0) begin
         errors++;
         $display("FAIL zero_mask_hit: cycles=%0d new_reads=%0d, required 1 and 0", cyc, n_rd_req - rd0);
      end
   endtask

   initial begin
      mem_model[32'h100] = 32'hDEADBEEF;
      test_reset();
      test_cold_load();
      test_store_hit();
      test_store_miss();
      test_same_cycle();
      test_alias();
      test_reset_mid();
      test_zero_mask();
      repeat (2) idle_cycle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d completions outstanding, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
Direct-mapped, write-through, no-write-allocate data cache. It answers the core's load requests from LoadStore and committed store requests from the ROB. It sits outside the core, on the far side of the lsm_dcache_* and rob_dcache_* interfaces, and fronts a simple word-wide memory port. One word per line.

Parameters:
ADDR_WIDTH, 32, byte address width (matches `Addr_Width)
DATA_WIDTH, 32, word width (matches `Data_Width)
INDEX_BITS, 6, log2 of line count (64 lines)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
lsm_dcache_read  in  1  load request, level-held until read_done
lsm_dcache_read_addr  in  ADDR_WIDTH  load byte address
dcache_lsm_read_done  out  1  one-cycle load completion pulse
dcache_lsm_read_data  out  DATA_WIDTH  load data
rob_dcache_write  in  1  store request, level-held until valid
rob_dcache_mask  in  4  byte enables, bit i selects bits [8i+7:8i]
rob_dcache_addr  in  ADDR_WIDTH  store byte address
rob_dcache_data  in  DATA_WIDTH  store data
dcache_rob_valid  out  1  one-cycle store completion pulse
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  word-aligned memory address
mem_wdata  out  DATA_WIDTH  write data
mem_mask  out  4  write byte enables
mem_ack  in  1  one-cycle completion from memory
mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack

Behaviour:
- Address split: addr[1:0] ignored. index = addr[INDEX_BITS+1:2]. tag = addr[ADDR_WIDTH-1:INDEX_BITS+2]. mem_addr is always {addr[ADDR_WIDTH-1:2],2'b00}.
- Storage per line: valid bit, tag, data word. All valid bits are reset-cleared. Tag and data arrays have no reset.
- Reset values: all outputs 0, FSM in IDLE.
- FSM states: IDLE, RD_MEM, WR_MEM, RD_RESP, WR_RESP.
- IDLE, arbitration: if rob_dcache_write is high, the store wins. Stores commit in order, so a same-cycle load to the same address sees the store data. Otherwise lsm_dcache_read is served. With neither request, stay in IDLE.
- IDLE, store: latch addr, data and mask; drive mem_req=1, mem_we=1, mem_wdata, mem_mask; go to WR_MEM.
- WR_MEM: hold all mem_* stable. On mem_ack: drop mem_req. If the line is valid with a matching tag, merge the masked bytes into the cached word; on a miss, leave the cache unchanged. Go to WR_RESP.
- WR_RESP: dcache_rob_valid=1 for exactly this cycle, then IDLE. Store latency is memory latency + 2 cycles.
- IDLE, load hit (valid and tag match): go to RD_RESP with dcache_lsm_read_data = cached word. Load-hit latency is 1 cycle: done is high in the cycle after the request is first seen in IDLE.
- IDLE, load miss: mem_req=1, mem_we=0, mem_mask=4'b0000; go to RD_MEM.
- RD_MEM: on mem_ack, fill the line (valid=1, tag, mem_rdata), load read_data from mem_rdata, drop mem_req, go to RD_RESP.
- RD_RESP: dcache_lsm_read_done=1 for exactly this cycle, then IDLE. read_data holds until the next load response.
- Requester rule: each requester deasserts its request on the clock edge that ends its done/valid pulse. IDLE is therefore never entered with a stale request. A request still high on entry to IDLE is treated as a new request.
- Mask 4'b0000 store: still performs the memory transaction and pulses valid, with no data change.
- Requests arriving outside IDLE are ignored until IDLE. Both requests are level-held, so none are lost.
- mem_ack outside RD_MEM/WR_MEM is ignored.
- Reset mid-operation: FSM returns to IDLE, all lines are invalidated, and mem_req drops at once. Any outstanding memory transaction is abandoned, and the memory model must tolerate this.
- Index wrap: addresses differing only in tag alias to one line; a fill replaces the previous tag.

Decomposition:
- Shared package (defines.v): Addr_Width, Data_Width, DCache_Index_Width, and FSM state encodings. Byte-mask width is fixed at 4.
- Natural sub-module: dcache_line_array. It holds the valid/tag/data arrays and provides a combinational hit lookup, a fill port and a masked byte-write port. data_cache keeps the FSM, arbitration and memory port.

Test Plan:
- Cold load to 0x100, memory returns 0xDEADBEEF after 3 cycles -> mem_req with mem_we=0 and mem_addr=0x100; read_done pulses once with data 0xDEADBEEF. A repeat load to 0x100 completes 1 cycle after request with no mem_req.
- Store to 0x100 (line resident), data 0x11223344, mask 4'b0011 -> mem write with mask 0011; rob_valid pulses once. A following load of 0x100 hits and returns 0xDEAD3344.
- Store to uncached 0x200 -> mem write and rob_valid pulse. A following load of 0x200 misses (no write-allocate) and issues a mem read.
- Load and store asserted in the same cycle to 0x300 -> store is served first with rob_valid; the load then misses and returns the memory value, with read_done after rob_valid.
- Alias: load 0x100, then load 0x100 + (64<<2) = 0x200 fills the same index -> the next load of 0x100 misses again.
- Assert rst while in RD_MEM -> mem_req falls with no clock edge. After release, a load of 0x100 misses (valid bits cleared), and both done outputs stay 0 during reset.
